// File: rtl/gate_tt_if.sv
// Handshake and result bundle between a test host and the gate truth-table sequencer.
// The host drives start/abort and the gate output. The sequencer drives stimulus and status.
interface gate_tt_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            abort;
    logic            dut_out;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] fail_vec;
    logic            fail_valid;

    modport master (
        output start, abort, dut_out,
        input  vec, busy, done, pass, err_cnt, fail_vec, fail_valid
    );

    modport slave (
        input  start, abort, dut_out,
        output vec, busy, done, pass, err_cnt, fail_vec, fail_valid
    );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Clocked exhaustive stimulus walker for small combinational gates.
// Holds each vector for SETTLE+1 cycles, then checks the output against EXPECT.
module gate_tt_sequencer #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b1000
) (
    input logic      clk,
    input logic      rst_n,
    gate_tt_if.slave bus
);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(2**N_IN - 1);
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state_q, state_nxt;
    logic [N_IN-1:0] idx_q, idx_nxt;
    logic [3:0]      cnt_q, cnt_nxt;
    logic [N_IN:0]   err_q, err_nxt;
    logic [N_IN-1:0] fvec_q, fvec_nxt;
    logic            fval_q, fval_nxt;
    logic            busy_q, done_q, pass_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            fvec_q  <= fvec_nxt;
            fval_q  <= fval_nxt;
            busy_q  <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
            done_q  <= (state_nxt == DONE);
            pass_q  <= (state_nxt == DONE) && (err_nxt == '0);
        end
    end

    // abort wins over everything; start is only honoured from IDLE or DONE
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        fvec_nxt  = fvec_q;
        fval_nxt  = fval_q;
        if (bus.abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            err_nxt   = '0;
            fvec_nxt  = '0;
            fval_nxt  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_nxt = DRIVE;
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                        err_nxt   = '0;
                        fvec_nxt  = '0;
                        fval_nxt  = 1'b0;
                    end
                end
                DRIVE: begin
                    cnt_nxt = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) state_nxt = SAMPLE;
                end
                SAMPLE: begin
                    if (bus.dut_out != EXPECT[idx_q]) begin
                        err_nxt = err_q + ERR_ONE;
                        if (!fval_q) begin
                            fvec_nxt = idx_q;
                            fval_nxt = 1'b1;
                        end
                    end
                    if (idx_q == LAST_VEC) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DRIVE;
                        idx_nxt   = idx_q + IDX_ONE;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.vec        = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_vec   = fvec_q;
    assign bus.fail_valid = fval_q;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Randomized bench for gate_tt_sequencer with a truth-table reference model.
// Two instances: default SETTLE=2 and an override with SETTLE=1.
module tb_gate_tt_sequencer;
    localparam logic [3:0] AND2 = 4'b1000;
    localparam logic [3:0] OR2  = 4'b1110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    gate_tt_if #(.N_IN(2)) ifa ();
    gate_tt_if #(.N_IN(2)) ifb ();

    gate_tt_sequencer #(.N_IN(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    gate_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic [3:0] tbl [2];
    logic       st  [2];
    logic       ab  [2];
    logic [1:0] o_vec [2];
    logic [2:0] o_err [2];
    logic [1:0] o_fvec[2];
    logic       o_busy[2], o_done[2], o_pass[2], o_fval[2];

    assign ifa.start   = st[0];
    assign ifa.abort   = ab[0];
    assign ifa.dut_out = tbl[0][ifa.vec];
    assign ifb.start   = st[1];
    assign ifb.abort   = ab[1];
    assign ifb.dut_out = tbl[1][ifb.vec];

    assign o_vec[0] = ifa.vec;      assign o_vec[1] = ifb.vec;
    assign o_err[0] = ifa.err_cnt;  assign o_err[1] = ifb.err_cnt;
    assign o_fvec[0] = ifa.fail_vec; assign o_fvec[1] = ifb.fail_vec;
    assign o_busy[0] = ifa.busy;    assign o_busy[1] = ifb.busy;
    assign o_done[0] = ifa.done;    assign o_done[1] = ifb.done;
    assign o_pass[0] = ifa.pass;    assign o_pass[1] = ifb.pass;
    assign o_fval[0] = ifa.fail_valid; assign o_fval[1] = ifb.fail_valid;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: mismatches are the set bits of gate^expect
    function automatic int m_err(input logic [3:0] g, input logic [3:0] e);
        int n = 0;
        for (int i = 0; i < 4; i++) if (g[i] != e[i]) n++;
        return n;
    endfunction

    function automatic int m_first(input logic [3:0] g, input logic [3:0] e);
        for (int i = 0; i < 4; i++) if (g[i] != e[i]) return i;
        return 0;
    endfunction

    task automatic chk_idle(input int d);
        chk("idle_vec",  o_vec[d],  0);
        chk("idle_busy", o_busy[d], 0);
        chk("idle_done", o_done[d], 0);
        chk("idle_pass", o_pass[d], 0);
        chk("idle_err",  o_err[d],  0);
        chk("idle_fvec", o_fvec[d], 0);
        chk("idle_fval", o_fval[d], 0);
    endtask

    // kick_t: extra start pulse; abort_t/rst_t: interrupt the run at that cycle
    task automatic run(input int d, input logic [3:0] g, input int kick_t,
                       input int abort_t, input int rst_t);
        int per, len, ne;
        per = (d == 0) ? 3 : 2;
        len = 4 * per;
        tbl[d] = g;
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        for (int t = 0; t < len; t++) begin
            chk("run_vec",  o_vec[d],  t / per);
            chk("run_busy", o_busy[d], 1);
            chk("run_done", o_done[d], 0);
            if (t == abort_t) begin
                ab[d] = 1'b1;
                tick();
                ab[d] = 1'b0;
                chk_idle(d);
                return;
            end
            if (t == rst_t) begin
                rst_n = 1'b0;
                #1;
                chk_idle(d);
                #2 rst_n = 1'b1;
                repeat (3) tick();
                chk_idle(d);
                return;
            end
            if (t == kick_t) st[d] = 1'b1;
            tick();
            st[d] = 1'b0;
        end
        ne = m_err(g, AND2);
        chk("end_done", o_done[d], 1);
        chk("end_busy", o_busy[d], 0);
        chk("end_vec",  o_vec[d],  3);
        chk("end_err",  o_err[d],  ne);
        chk("end_pass", o_pass[d], (ne == 0) ? 1 : 0);
        chk("end_fval", o_fval[d], (ne != 0) ? 1 : 0);
        chk("end_fvec", o_fvec[d], m_first(g, AND2));
        tick();
        chk("hold_done", o_done[d], 1);
        chk("hold_err",  o_err[d],  ne);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            tbl[i] = AND2;
            st[i]  = 1'b0;
            ab[i]  = 1'b0;
        end
        repeat (2) tick();
        chk_idle(0);
        chk_idle(1);
        rst_n = 1'b1;
        tick();
        chk_idle(0);

        run(0, AND2, -1, -1, -1);
        run(0, OR2, -1, -1, -1);
        run(0, 4'b0000, -1, -1, -1);
        run(0, 4'b1111, -1, -1, -1);
        run(0, AND2, 6, -1, -1);
        run(0, AND2, -1, -1, 5);
        run(0, AND2, -1, -1, -1);

        run(0, OR2, -1, -1, -1);
        st[0] = 1'b1;
        ab[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        ab[0] = 1'b0;
        chk_idle(0);
        tick();
        chk_idle(0);
        run(1, AND2, -1, -1, -1);

        for (int k = 0; k < 24; k++) begin
            int d, at;
            logic [3:0] g;
            d  = int'($urandom_range(0, 1));
            g  = 4'($urandom_range(0, 15));
            at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (d == 0) ? 11 : 7)) : -1;
            run(d, g, -1, at, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
